memristor_pulse_sequencer: RTL

Programmable write-pulse sequencer sitting directly upstream of the three-channel memristor core. It replaces fixed single-level toggling with timed pulse trains. Each train selects one memristor channel (SEL), drives its DIGITALIN line with N pulses of programmable width, gap and polarity, and reports completion. Configuration and start come from logic-analyzer (LA) registers. SEL/DIGITALIN outputs are muxed onto the core's select/data pins in place of the io_in path.

---
 rtl/memristor_pulse_sequencer_if.sv | 29 ++
 rtl/memristor_pulse_sequencer.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/memristor_pulse_sequencer_if.sv
// Control/status bundle between the LA register block (master) and the pulse sequencer (slave).
interface memristor_pulse_sequencer_if #(
  parameter int CNT_W = 8
);
  logic             start;
  logic             abort;
  logic [1:0]       cfg_chan;
  logic             cfg_pol;
  logic [CNT_W-1:0] cfg_num;
  logic [CNT_W-1:0] cfg_width;
  logic [CNT_W-1:0] cfg_gap;
  logic [2:0]       sel;
  logic [2:0]       din;
  logic             busy;
  logic             done;
  logic             aborted;
  logic             cfg_err;
  logic [CNT_W-1:0] pulses_done;

  modport master (
    output start, abort, cfg_chan, cfg_pol, cfg_num, cfg_width, cfg_gap,
    input  sel, din, busy, done, aborted, cfg_err, pulses_done
  );

  modport slave (
    input  start, abort, cfg_chan, cfg_pol, cfg_num, cfg_width, cfg_gap,
    output sel, din, busy, done, aborted, cfg_err, pulses_done
  );
endinterface

// File: rtl/memristor_pulse_sequencer.sv
// Timed write-pulse train generator for the three-channel memristor core; drives the
// core's one-hot select and DIGITALIN lines from a latched configuration.
module memristor_pulse_sequencer #(
  parameter int CNT_W        = 8,
  parameter int SETUP_CYCLES = 2
) (
  input logic                      wb_clk_i,
  input logic                      wb_rst_n,
  memristor_pulse_sequencer_if.slave bus
);

  localparam int SW = $clog2(SETUP_CYCLES + 1);
  localparam int CW = (CNT_W > SW) ? CNT_W : SW;
  localparam logic [CW-1:0] SETUP_LOAD = CW'(SETUP_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, SETUP, PULSE, GAP, HOLD} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic [1:0]       chan, chan_nxt;
  logic             pol, pol_nxt;
  logic [CNT_W-1:0] num, num_nxt;
  logic [CNT_W-1:0] width, width_nxt;
  logic [CNT_W-1:0] gap, gap_nxt;
  logic [CNT_W-1:0] pulses, pulses_nxt;
  logic [2:0]       sel_nxt, din_nxt, onehot;
  logic             done_nxt, aborted_nxt, cfg_err_nxt, busy_nxt, cfg_ok;

  // Down-counter reload for a phase of max(v,1) cycles.
  function automatic logic [CW-1:0] load_of(input logic [CNT_W-1:0] v);
    return (v == '0) ? '0 : (CW'(v) - CW'(1));
  endfunction

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    chan_nxt    = chan;
    pol_nxt     = pol;
    num_nxt     = num;
    width_nxt   = width;
    gap_nxt     = gap;
    pulses_nxt  = pulses;
    done_nxt    = 1'b0;
    aborted_nxt = 1'b0;
    cfg_err_nxt = 1'b0;
    cfg_ok      = (bus.cfg_chan != 2'd3) && (bus.cfg_num != '0);

    case (state)
      IDLE: begin
        if (bus.start) begin
          if (cfg_ok) begin
            chan_nxt   = bus.cfg_chan;
            pol_nxt    = bus.cfg_pol;
            num_nxt    = bus.cfg_num;
            width_nxt  = bus.cfg_width;
            gap_nxt    = bus.cfg_gap;
            pulses_nxt = '0;
            cnt_nxt    = SETUP_LOAD;
            state_nxt  = SETUP;
          end else begin
            cfg_err_nxt = 1'b1;
          end
        end
      end
      SETUP: begin
        if (cnt == '0) begin
          cnt_nxt   = load_of(width);
          state_nxt = PULSE;
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      PULSE: begin
        // Compare before incrementing so a full-scale pulse count never wraps.
        if (cnt == '0) begin
          pulses_nxt = pulses + CNT_W'(1);
          if ((pulses + CNT_W'(1)) == num) begin
            cnt_nxt   = SETUP_LOAD;
            state_nxt = HOLD;
          end else begin
            cnt_nxt   = load_of(gap);
            state_nxt = GAP;
          end
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      GAP: begin
        if (cnt == '0) begin
          cnt_nxt   = load_of(width);
          state_nxt = PULSE;
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      HOLD: begin
        if (cnt == '0) begin
          cnt_nxt   = '0;
          done_nxt  = 1'b1;
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase

    if (bus.abort && (state != IDLE)) begin
      state_nxt   = IDLE;
      cnt_nxt     = '0;
      pulses_nxt  = pulses;
      done_nxt    = 1'b1;
      aborted_nxt = 1'b1;
    end

    // Outputs are decoded from the next state so they come straight out of flops.
    onehot   = 3'b001 << chan_nxt;
    sel_nxt  = 3'b000;
    din_nxt  = 3'b000;
    busy_nxt = (state_nxt != IDLE);
    case (state_nxt)
      SETUP, GAP, HOLD: begin
        sel_nxt = onehot;
        din_nxt = pol_nxt ? onehot : 3'b000;
      end
      PULSE: begin
        sel_nxt = onehot;
        din_nxt = pol_nxt ? 3'b000 : onehot;
      end
      default: begin
        sel_nxt = 3'b000;
        din_nxt = 3'b000;
      end
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      chan        <= '0;
      pol         <= 1'b0;
      num         <= '0;
      width       <= '0;
      gap         <= '0;
      pulses      <= '0;
      bus.sel     <= '0;
      bus.din     <= '0;
      bus.busy    <= 1'b0;
      bus.done    <= 1'b0;
      bus.aborted <= 1'b0;
      bus.cfg_err <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      chan        <= chan_nxt;
      pol         <= pol_nxt;
      num         <= num_nxt;
      width       <= width_nxt;
      gap         <= gap_nxt;
      pulses      <= pulses_nxt;
      bus.sel     <= sel_nxt;
      bus.din     <= din_nxt;
      bus.busy    <= busy_nxt;
      bus.done    <= done_nxt;
      bus.aborted <= aborted_nxt;
      bus.cfg_err <= cfg_err_nxt;
    end
  end

  assign bus.pulses_done = pulses;

endmodule
